// File: rtl/board_pkg.sv
// Shared constants, arbiter state type and address helper for the game-board RAM.
package board_pkg;

  localparam logic [31:0] BOARD_BASE  = 32'h0000_1000;
  localparam int unsigned BOARD_CELLS = 100;
  localparam int unsigned BOARD_IDX_W = 7;
  localparam logic [31:0] BOARD_END   = BOARD_BASE + 32'(4 * BOARD_CELLS);

  typedef enum logic [0:0] {ARB_IDLE, ARB_CLEAR} arb_state_t;

  // Word index to byte address inside the board window.
  function automatic logic [31:0] idx2addr(input logic [BOARD_IDX_W-1:0] idx);
    return ({25'b0, idx} << 2) + BOARD_BASE;
  endfunction

endpackage

// File: rtl/board_clear_seq.sv
// Board clear sequencer: start/busy/done handshake and the word sweep counter.
module board_clear_seq
  import board_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [BOARD_IDX_W-1:0] cnt
);

  localparam logic [BOARD_IDX_W-1:0] LAST_IDX = BOARD_IDX_W'(BOARD_CELLS - 1);

  arb_state_t             state_q, state_d;
  logic [BOARD_IDX_W-1:0] cnt_q, cnt_d;
  logic                   done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // start is ignored once the sweep is running
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (start) begin
          state_d = ARB_CLEAR;
          cnt_d   = '0;
        end
      end
      ARB_CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ARB_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + BOARD_IDX_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == ARB_CLEAR);
  assign done = done_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/board_mem_arbiter.sv
// Single-port arbiter in front of the board RAM: CPU, video scanner and clear engine.
module board_mem_arbiter
  import board_pkg::*;
#(
  parameter int unsigned VID_MAX_WAIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_we,
  input  logic                   cpu_re,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_stall,
  input  logic                   vid_req,
  input  logic [BOARD_IDX_W-1:0] vid_index,
  output logic                   vid_gnt,
  output logic                   vid_rvalid,
  output logic [31:0]            vid_rdata,
  input  logic                   clr_start,
  output logic                   clr_busy,
  output logic                   clr_done,
  output logic                   ram_we,
  output logic [31:0]            ram_addr,
  output logic [31:0]            ram_wdata,
  input  logic [31:0]            ram_rdata
);

  localparam int unsigned WAIT_W = $clog2(VID_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(VID_MAX_WAIT);

  logic [BOARD_IDX_W-1:0] clr_cnt;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   cpu_hit;
  logic                   forced;
  logic                   vid_in_range;

  board_clear_seq u_clear (
    .clk   (clk),
    .rst   (rst),
    .start (clr_start),
    .busy  (clr_busy),
    .done  (clr_done),
    .cnt   (clr_cnt)
  );

  assign cpu_hit      = (cpu_we | cpu_re) && (cpu_addr >= BOARD_BASE) && (cpu_addr < BOARD_END);
  assign forced       = (wait_q == WAIT_MAX);
  assign vid_in_range = (vid_index < BOARD_IDX_W'(BOARD_CELLS));
  assign cpu_rdata    = ram_rdata;

  // RAM ownership: clear sweep, then forced video > CPU > video
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    cpu_stall = 1'b0;
    vid_gnt   = 1'b0;
    if (clr_busy) begin
      ram_we    = 1'b1;
      ram_addr  = idx2addr(clr_cnt);
      cpu_stall = cpu_hit;
    end else if (vid_req && (forced || !cpu_hit)) begin
      vid_gnt   = 1'b1;
      ram_addr  = idx2addr(vid_index);
      cpu_stall = cpu_hit;
    end else if (cpu_hit) begin
      ram_we    = cpu_we;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end
  end

  // Video starvation counter, frozen while the clear sweep owns the RAM
  always_comb begin
    wait_d = wait_q;
    if (!clr_busy) begin
      if (!vid_req || vid_gnt) begin
        wait_d = '0;
      end else if (wait_q != WAIT_MAX) begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q     <= '0;
      vid_rvalid <= 1'b0;
      vid_rdata  <= '0;
    end else begin
      wait_q     <= wait_d;
      vid_rvalid <= vid_gnt;
      if (vid_gnt) begin
        vid_rdata <= vid_in_range ? ram_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench for board_mem_arbiter with a behavioural negedge-write board RAM.
module tb_board_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_we, cpu_re;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        vid_req;
  logic [6:0]  vid_index;
  logic        vid_gnt, vid_rvalid;
  logic [31:0] vid_rdata;
  logic        clr_start, clr_busy, clr_done;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  int n_pass  = 0;
  int n_total = 0;

  board_mem_arbiter #(.VID_MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .vid_req(vid_req), .vid_index(vid_index), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board RAM: combinational read, write on negedge
  logic [31:0] mem [0:99];
  logic [31:0] off;
  logic        in_win;
  assign off    = ram_addr - 32'h1000;
  assign in_win = (ram_addr >= 32'h1000) && (ram_addr < 32'h1190);

  always_comb begin
    ram_rdata = 32'h0;
    if (in_win) ram_rdata = mem[off[8:2]];
  end

  always @(negedge clk) begin
    if (ram_we && in_win) mem[off[8:2]] <= ram_wdata;
  end

  typedef struct {
    logic        we, re;
    logic [31:0] addr, wdata;
    logic        vreq;
    logic [6:0]  vidx;
    logic        e_stall, e_gnt, e_we;
    logic        chk_addr;
    logic [31:0] e_addr;
    logic        chk_rd;
    logic [31:0] e_rd;
    logic        e_rvalid;
    logic [31:0] e_vrd;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    check(nm, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_we = 0; cpu_re = 0; cpu_addr = 0; cpu_wdata = 0;
    vid_req = 0; vid_index = 0; clr_start = 0;
  endtask

  initial begin
    // we re addr wdata vreq vidx | stall gnt we chka addr chkr rd rvalid vrd
    vecs[0]  = '{1'b1,1'b0,32'h1014,32'h1234_5678,1'b0,7'd0,  1'b0,1'b0,1'b1,1'b1,32'h1014,1'b0,32'h0,    1'b0,32'h0};
    vecs[1]  = '{1'b1,1'b0,32'h1004,32'h0000_DEAD,1'b0,7'd0,  1'b0,1'b0,1'b1,1'b1,32'h1004,1'b0,32'h0,    1'b0,32'h0};
    vecs[2]  = '{1'b0,1'b1,32'h1004,32'h0,        1'b0,7'd0,  1'b0,1'b0,1'b0,1'b1,32'h1004,1'b1,32'hDEAD, 1'b0,32'h0};
    vecs[3]  = '{1'b1,1'b0,32'h2000,32'h1111_1111,1'b0,7'd0,  1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,    1'b0,32'h0};
    vecs[4]  = '{1'b1,1'b0,32'h0FFC,32'h2222_2222,1'b0,7'd0,  1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,    1'b0,32'h0};
    vecs[5]  = '{1'b1,1'b0,32'h118C,32'h0000_0055,1'b0,7'd0,  1'b0,1'b0,1'b1,1'b1,32'h118C,1'b0,32'h0,    1'b0,32'h0};
    vecs[6]  = '{1'b0,1'b1,32'h1190,32'h0,        1'b0,7'd0,  1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,    1'b0,32'h0};
    vecs[7]  = '{1'b0,1'b0,32'h0,   32'h0,        1'b1,7'd5,  1'b0,1'b1,1'b0,1'b1,32'h1014,1'b0,32'h0,    1'b1,32'h1234_5678};
    vecs[8]  = '{1'b1,1'b0,32'h2000,32'h7,        1'b1,7'd5,  1'b0,1'b1,1'b0,1'b1,32'h1014,1'b0,32'h0,    1'b1,32'h1234_5678};
    vecs[9]  = '{1'b0,1'b1,32'h1004,32'h0,        1'b1,7'd0,  1'b0,1'b0,1'b0,1'b1,32'h1004,1'b1,32'hDEAD, 1'b0,32'h0};
    vecs[10] = '{1'b0,1'b0,32'h0,   32'h0,        1'b1,7'd120,1'b0,1'b1,1'b0,1'b1,32'h11E0,1'b0,32'h0,    1'b1,32'h0};
    vecs[11] = '{1'b1,1'b0,32'h1000,32'h0000_AAAA,1'b0,7'd0,  1'b0,1'b0,1'b1,1'b1,32'h1000,1'b0,32'h0,    1'b0,32'h0};
    vecs[12] = '{1'b1,1'b0,32'h118C,32'h0000_BBBB,1'b0,7'd0,  1'b0,1'b0,1'b1,1'b1,32'h118C,1'b0,32'h0,    1'b0,32'h0};
    vecs[13] = '{1'b0,1'b0,32'h0,   32'h0,        1'b1,7'd99, 1'b0,1'b1,1'b0,1'b1,32'h118C,1'b0,32'h0,    1'b1,32'h0000_BBBB};
    vecs[14] = '{1'b0,1'b0,32'h0,   32'h0,        1'b0,7'd0,  1'b0,1'b0,1'b0,1'b0,32'h0,   1'b0,32'h0,    1'b0,32'h0};

    rst = 1'b1;
    idle_inputs();
    #12;
    check1("rst_clr_busy", clr_busy, 1'b0);
    check1("rst_clr_done", clr_done, 1'b0);
    check1("rst_vid_rvalid", vid_rvalid, 1'b0);
    check("rst_vid_rdata", vid_rdata, 32'h0);
    check1("rst_ram_we", ram_we, 1'b0);
    check1("rst_vid_gnt", vid_gnt, 1'b0);
    check1("rst_cpu_stall", cpu_stall, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Single-cycle IDLE arbitration vectors
    for (int i = 0; i < 15; i++) begin
      cpu_we = vecs[i].we; cpu_re = vecs[i].re;
      cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
      vid_req = vecs[i].vreq; vid_index = vecs[i].vidx;
      #2;
      check1($sformatf("v%0d_cpu_stall", i), cpu_stall, vecs[i].e_stall);
      check1($sformatf("v%0d_vid_gnt", i), vid_gnt, vecs[i].e_gnt);
      check1($sformatf("v%0d_ram_we", i), ram_we, vecs[i].e_we);
      if (vecs[i].chk_addr) check($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].e_addr);
      if (vecs[i].e_we) check($sformatf("v%0d_ram_wdata", i), ram_wdata, vecs[i].wdata);
      if (vecs[i].chk_rd) check($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vecs[i].e_rd);
      tick();
      check1($sformatf("v%0d_vid_rvalid", i), vid_rvalid, vecs[i].e_rvalid);
      if (vecs[i].e_rvalid) check($sformatf("v%0d_vid_rdata", i), vid_rdata, vecs[i].e_vrd);
    end
    idle_inputs();
    tick();

    // Video starvation: forced grant on the 9th denied-then-forced cycle
    cpu_re = 1; cpu_addr = 32'h1008; vid_req = 1; vid_index = 7'd3;
    for (int c = 1; c <= 10; c++) begin
      #2;
      check1($sformatf("starve_c%0d_gnt", c), vid_gnt, c == 9);
      check1($sformatf("starve_c%0d_stall", c), cpu_stall, c == 9);
      check($sformatf("starve_c%0d_addr", c), ram_addr, (c == 9) ? 32'h100C : 32'h1008);
      tick();
    end
    idle_inputs();
    tick();

    // Full clear sweep with words 0 and 99 preloaded
    clr_start = 1;
    #2;
    check1("clr1_pulse_busy", clr_busy, 1'b0);
    tick();
    clr_start = 0;
    for (int k = 0; k < 100; k++) begin
      #2;
      check1($sformatf("clr1_k%0d_busy", k), clr_busy, 1'b1);
      check1($sformatf("clr1_k%0d_we", k), ram_we, 1'b1);
      check($sformatf("clr1_k%0d_addr", k), ram_addr, 32'h1000 + 32'(4 * k));
      check1($sformatf("clr1_k%0d_done", k), clr_done, 1'b0);
      tick();
    end
    #2;
    check1("clr1_done_pulse", clr_done, 1'b1);
    check1("clr1_busy_end", clr_busy, 1'b0);
    tick();
    check1("clr1_done_once", clr_done, 1'b0);
    cpu_re = 1; cpu_addr = 32'h1000;
    #2;
    check("clr1_word0", cpu_rdata, 32'h0);
    tick();
    cpu_addr = 32'h118C;
    #2;
    check("clr1_word99", cpu_rdata, 32'h0);
    tick();
    idle_inputs();

    // CPU stalled throughout a sweep; a second start does not extend it
    clr_start = 1;
    tick();
    clr_start = 0;
    cpu_re = 1; cpu_addr = 32'h1004;
    for (int k = 0; k < 100; k++) begin
      clr_start = (k == 10);
      #2;
      check1($sformatf("clr2_k%0d_stall", k), cpu_stall, 1'b1);
      check1($sformatf("clr2_k%0d_busy", k), clr_busy, 1'b1);
      tick();
    end
    clr_start = 0;
    #2;
    check1("clr2_done_pulse", clr_done, 1'b1);
    check1("clr2_stall_released", cpu_stall, 1'b0);
    check1("clr2_not_extended", clr_busy, 1'b0);
    tick();
    idle_inputs();
    tick();

    // Reset mid-sweep aborts without clr_done; fresh start begins at word 0
    clr_start = 1;
    tick();
    clr_start = 0;
    for (int k = 0; k < 40; k++) tick();
    #1;
    check("rstmid_addr_cnt40", ram_addr, 32'h10A0);
    #1;
    rst = 1;
    #1;
    check1("rstmid_busy_now", clr_busy, 1'b0);
    check1("rstmid_we_now", ram_we, 1'b0);
    tick();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check1($sformatf("rstmid_nodone_%0d", k), clr_done, 1'b0);
      check1($sformatf("rstmid_idle_%0d", k), clr_busy, 1'b0);
      tick();
    end
    clr_start = 1;
    tick();
    clr_start = 0;
    #1;
    check1("restart_busy", clr_busy, 1'b1);
    check("restart_addr", ram_addr, 32'h1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
